chain_feeder: RTL and testbench

//  Upstream controller for the CPE register chain. Streams one tile, row-major, from the tile

---
 rtl/cpe_pkg.sv | 16 +
 rtl/tile_pos_counter.sv | 36 +++
 rtl/chain_feeder.sv | 155 +++++++++++++++
 tb/tb_chain_feeder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpe_pkg.sv
// Shared definitions for the CPE datapath: default widths, kernel edge and the feeder FSM states.
package cpe_pkg;

    localparam int WIDTH       = 16;
    localparam int SEL_WIDTH   = 5;
    localparam int ADDR_WIDTH  = 10;
    localparam int KERNEL_SIZE = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/tile_pos_counter.sv
// Row-major (row, col) position inside a tile; col wraps at last_col, then row advances.
module tile_pos_counter #(
    parameter int COL_WIDTH = cpe_pkg::SEL_WIDTH,
    parameter int ROW_WIDTH = cpe_pkg::ADDR_WIDTH
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [COL_WIDTH-1:0] last_col,
    input  logic [ROW_WIDTH-1:0] last_row,
    output logic [ROW_WIDTH-1:0] row,
    output logic [COL_WIDTH-1:0] col,
    output logic                 last
);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == last_col) begin
                col <= '0;
                row <= row + ROW_WIDTH'(1);
            end else begin
                col <= col + COL_WIDTH'(1);
            end
        end
    end

    assign last = (row == last_row) && (col == last_col);

endmodule

// File: rtl/chain_feeder.sv
// Streams one tile row-major from the tile buffer into the CPE register chain and flags
// every cycle in which the chain holds a complete KxK window.
module chain_feeder #(
    parameter int WIDTH       = cpe_pkg::WIDTH,
    parameter int SEL_WIDTH   = cpe_pkg::SEL_WIDTH,
    parameter int ADDR_WIDTH  = cpe_pkg::ADDR_WIDTH,
    parameter int KERNEL_SIZE = cpe_pkg::KERNEL_SIZE
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [SEL_WIDTH:0]    tile_width,
    input  logic [ADDR_WIDTH-1:0] tile_height,
    input  logic                  stall,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [WIDTH-1:0]      rd_data,
    output logic [WIDTH-1:0]      pixel_out,
    output logic                  chain_run,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  window_valid,
    output logic [ADDR_WIDTH-1:0] win_row,
    output logic [SEL_WIDTH-1:0]  win_col,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    import cpe_pkg::*;

    localparam logic [SEL_WIDTH:0]    MIN_W    = (SEL_WIDTH+1)'(KERNEL_SIZE);
    localparam logic [SEL_WIDTH:0]    MAX_W    = (SEL_WIDTH+1)'(2**SEL_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] MIN_H    = ADDR_WIDTH'(KERNEL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] EDGE_ROW = ADDR_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [SEL_WIDTH-1:0]  EDGE_COL = SEL_WIDTH'(KERNEL_SIZE - 1);

    feeder_state_t          state;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [ADDR_WIDTH-1:0]  height_q;
    logic [ADDR_WIDTH-1:0]  issue_cnt;
    logic [ADDR_WIDTH-1:0]  issue_row;
    logic [SEL_WIDTH-1:0]   issue_col;
    logic                   issue_last;
    logic [ADDR_WIDTH-1:0]  shift_row;
    logic [SEL_WIDTH-1:0]   shift_col;
    logic                   shift_last;
    logic                   start_ok;
    logic                   accept;
    logic                   at_window;
    logic                   unused_issue_pos;

    assign start_ok  = (tile_width >= MIN_W) && (tile_width <= MAX_W) && (tile_height >= MIN_H);
    assign accept    = start && (state == IDLE) && start_ok;
    assign rd_en     = (state == ISSUE) && !stall;
    assign rd_addr   = base_q + issue_cnt;
    assign busy      = (state != IDLE);
    assign pixel_out = chain_run ? rd_data : '0;
    assign at_window = (shift_row >= EDGE_ROW) && (shift_col >= EDGE_COL);

    // Only the end-of-tile flag of the issue position is consumed; the address is a flat count.
    assign unused_issue_pos = ^{issue_row, issue_col};

    tile_pos_counter #(.COL_WIDTH(SEL_WIDTH), .ROW_WIDTH(ADDR_WIDTH)) issue_pos (
        .clock    (clock),
        .rst_n    (rst_n),
        .clear    (accept),
        .advance  (rd_en),
        .last_col (sel),
        .last_row (height_q - ADDR_WIDTH'(1)),
        .row      (issue_row),
        .col      (issue_col),
        .last     (issue_last)
    );

    tile_pos_counter #(.COL_WIDTH(SEL_WIDTH), .ROW_WIDTH(ADDR_WIDTH)) shift_pos (
        .clock    (clock),
        .rst_n    (rst_n),
        .clear    (accept),
        .advance  (chain_run),
        .last_col (sel),
        .last_row (height_q - ADDR_WIDTH'(1)),
        .row      (shift_row),
        .col      (shift_col),
        .last     (shift_last)
    );

    // Tile sequencing; config is latched only on a legal start seen in IDLE.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            height_q  <= '0;
            sel       <= '0;
            issue_cnt <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            base_q    <= base_addr;
                            height_q  <= tile_height;
                            sel       <= tile_width[SEL_WIDTH-1:0] - SEL_WIDTH'(1);
                            issue_cnt <= '0;
                            state     <= ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (rd_en) begin
                        issue_cnt <= issue_cnt + ADDR_WIDTH'(1);
                        if (issue_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last pixel is on pixel_out now, so the shift position sits on the final slot.
                    done  <= shift_last;
                    state <= FLUSH;
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Chain strobe mirrors the one-cycle buffer latency; window flag follows each shift.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            chain_run    <= 1'b0;
            window_valid <= 1'b0;
            win_row      <= '0;
            win_col      <= '0;
        end else begin
            chain_run    <= rd_en;
            window_valid <= chain_run && at_window;
            if (chain_run && at_window) begin
                win_row <= shift_row;
                win_col <= shift_col;
            end
        end
    end

endmodule

// File: tb/tb_chain_feeder.sv
// Directed bench for chain_feeder with a one-cycle-latency tile buffer model.
module tb_chain_feeder;

    localparam int WIDTH      = 16;
    localparam int SEL_WIDTH  = 5;
    localparam int ADDR_WIDTH = 10;
    localparam int DATA_TAG   = 'h15 << ADDR_WIDTH;

    logic                  clock = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  stall = 1'b0;
    logic [ADDR_WIDTH-1:0] base_addr = '0;
    logic [SEL_WIDTH:0]    tile_width = '0;
    logic [ADDR_WIDTH-1:0] tile_height = '0;
    logic [WIDTH-1:0]      rd_data = '0;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WIDTH-1:0]      pixel_out;
    logic                  chain_run;
    logic [SEL_WIDTH-1:0]  sel;
    logic                  window_valid;
    logic [ADDR_WIDTH-1:0] win_row;
    logic [SEL_WIDTH-1:0]  win_col;
    logic                  busy;
    logic                  done;
    logic                  err;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;
    int err_cnt = 0;
    int addr_log[$];
    int pix_log[$];
    int win_log[$];
    int rd_cycle[$];
    int done_cycle[$];

    chain_feeder dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .tile_width   (tile_width),
        .tile_height  (tile_height),
        .stall        (stall),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pixel_out    (pixel_out),
        .chain_run    (chain_run),
        .sel          (sel),
        .window_valid (window_valid),
        .win_row      (win_row),
        .win_col      (win_col),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clock = ~clock;

    // Tile buffer model: data tags the address so pixel order can be checked.
    always @(posedge clock) begin
        cycle++;
        if (rd_en) rd_data <= WIDTH'(DATA_TAG | int'(rd_addr));
    end

    always @(negedge clock) begin
        if (rd_en) begin
            addr_log.push_back(int'(rd_addr));
            rd_cycle.push_back(cycle);
        end
        if (chain_run) pix_log.push_back(int'(pixel_out));
        if (window_valid) win_log.push_back(int'(win_row) * 64 + int'(win_col));
        if (done) done_cycle.push_back(cycle);
        if (err) err_cnt++;
    end

    task automatic clear_logs();
        addr_log.delete();
        pix_log.delete();
        win_log.delete();
        rd_cycle.delete();
        done_cycle.delete();
        err_cnt = 0;
    endtask

    task automatic start_tile(input int base, input int w, input int h);
        base_addr   = ADDR_WIDTH'(base);
        tile_width  = (SEL_WIDTH+1)'(w);
        tile_height = ADDR_WIDTH'(h);
        start       = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        compared++;
        if (done !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, n);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [51:0] outs;
        rst_n = 1'b0;
        #23;
        outs = {rd_en, rd_addr, chain_run, sel, window_valid, win_row, win_col, busy, done, err, pixel_out};
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", outs);
        end
        @(posedge clock);
        #1 rst_n = 1'b1;
        @(posedge clock);
        #1;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        int exp_win[4] = '{2*64+2, 2*64+3, 3*64+2, 3*64+3};
        int got;
        clear_logs();
        start_tile('h010, 4, 4);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_busy: got %b, required 1", busy); end
        compared++;
        if (sel !== 5'd3) begin mismatched++; $display("[TB] FAIL basic_sel: got %0d, required 3", sel); end
        wait_done(100, "basic");
        compared++;
        if (addr_log.size() != 16) begin mismatched++; $display("[TB] FAIL basic_read_count: got %0d, required 16", addr_log.size()); end
        compared++;
        if (pix_log.size() != 16) begin mismatched++; $display("[TB] FAIL basic_run_count: got %0d, required 16", pix_log.size()); end
        for (int i = 0; i < 16; i++) begin
            got = (i < addr_log.size()) ? addr_log[i] : -1;
            compared++;
            if (got != 'h010 + i) begin mismatched++; $display("[TB] FAIL basic_addr[%0d]: got %h, required %h", i, got, 'h010 + i); end
            got = (i < pix_log.size()) ? pix_log[i] : -1;
            compared++;
            if (got != (DATA_TAG | ('h010 + i))) begin mismatched++; $display("[TB] FAIL basic_pixel[%0d]: got %h, required %h", i, got, DATA_TAG | ('h010 + i)); end
        end
        compared++;
        if (win_log.size() != 4) begin mismatched++; $display("[TB] FAIL basic_window_count: got %0d, required 4", win_log.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < win_log.size()) ? win_log[i] : -1;
            compared++;
            if (got != exp_win[i]) begin mismatched++; $display("[TB] FAIL basic_window[%0d]: got row*64+col=%0d, required %0d", i, got, exp_win[i]); end
        end
        got = (done_cycle.size() > 0 && rd_cycle.size() > 0) ? done_cycle[0] - rd_cycle[rd_cycle.size()-1] : -1;
        compared++;
        if (got != 2) begin mismatched++; $display("[TB] FAIL basic_done_latency: got %0d cycles, required 2", got); end
        compared++;
        if (done_cycle.size() != 1) begin mismatched++; $display("[TB] FAIL basic_done_pulses: got %0d, required 1", done_cycle.size()); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_idle_after: got busy=%b, required 0", busy); end
        compared++;
        if (sel !== 5'd3) begin mismatched++; $display("[TB] FAIL basic_sel_hold: got %0d, required 3", sel); end
    endtask

    task automatic test_wide();
        int got;
        clear_logs();
        start_tile('h100, 32, 3);
        compared++;
        if (sel !== 5'd31) begin mismatched++; $display("[TB] FAIL wide_sel: got %0d, required 31", sel); end
        wait_done(200, "wide");
        compared++;
        if (addr_log.size() != 96) begin mismatched++; $display("[TB] FAIL wide_read_count: got %0d, required 96", addr_log.size()); end
        compared++;
        if (pix_log.size() != 96) begin mismatched++; $display("[TB] FAIL wide_run_count: got %0d, required 96", pix_log.size()); end
        got = (addr_log.size() > 0) ? addr_log[addr_log.size()-1] : -1;
        compared++;
        if (got != 'h15F) begin mismatched++; $display("[TB] FAIL wide_last_addr: got %h, required 15f", got); end
        compared++;
        if (win_log.size() != 30) begin mismatched++; $display("[TB] FAIL wide_window_count: got %0d, required 30", win_log.size()); end
        for (int i = 0; i < 30; i++) begin
            got = (i < win_log.size()) ? win_log[i] : -1;
            compared++;
            if (got != 2*64 + 2 + i) begin mismatched++; $display("[TB] FAIL wide_window[%0d]: got row*64+col=%0d, required %0d", i, got, 2*64 + 2 + i); end
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int budget = 0;
        int got;
        logic exp_run[3] = '{1'b1, 1'b0, 1'b0};
        clear_logs();
        start_tile('h040, 4, 4);
        while (n < 5 && budget < 50) begin
            @(negedge clock);
            if (rd_en) n++;
            budget++;
        end
        @(posedge clock);
        #1 stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            compared++;
            if (chain_run !== exp_run[i]) begin mismatched++; $display("[TB] FAIL stall_run[%0d]: got %b, required %b", i, chain_run, exp_run[i]); end
            compared++;
            if (rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_rd_en[%0d]: got %b, required 0", i, rd_en); end
        end
        @(posedge clock);
        #1 stall = 1'b0;
        wait_done(100, "stall");
        compared++;
        if (pix_log.size() != 16) begin mismatched++; $display("[TB] FAIL stall_run_count: got %0d, required 16", pix_log.size()); end
        for (int i = 0; i < 16; i++) begin
            got = (i < pix_log.size()) ? pix_log[i] : -1;
            compared++;
            if (got != (DATA_TAG | ('h040 + i))) begin mismatched++; $display("[TB] FAIL stall_pixel[%0d]: got %h, required %h", i, got, DATA_TAG | ('h040 + i)); end
        end
        compared++;
        if (win_log.size() != 4) begin mismatched++; $display("[TB] FAIL stall_window_count: got %0d, required 4", win_log.size()); end
    endtask

    task automatic test_illegal();
        int widths[3]  = '{2, 33, 4};
        int heights[3] = '{4, 4, 2};
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            start_tile('h000, widths[i], heights[i]);
            compared++;
            if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_err[%0d]: got %b, required 1", i, err); end
            compared++;
            if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL illegal_busy[%0d]: got %b, required 0", i, busy); end
            @(posedge clock);
            #1;
            compared++;
            if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL illegal_err_pulse[%0d]: got %b, required 0", i, err); end
        end
        repeat (3) @(posedge clock);
        #1;
        compared++;
        if (addr_log.size() != 0) begin mismatched++; $display("[TB] FAIL illegal_no_reads: got %0d reads, required 0", addr_log.size()); end
        compared++;
        if (err_cnt != 3) begin mismatched++; $display("[TB] FAIL illegal_err_cycles: got %0d, required 3", err_cnt); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int budget = 0;
        int got;
        logic [51:0] outs;
        clear_logs();
        start_tile('h080, 4, 4);
        while (n < 7 && budget < 50) begin
            @(negedge clock);
            if (rd_en) n++;
            budget++;
        end
        #2 rst_n = 1'b0;
        #1;
        outs = {rd_en, rd_addr, chain_run, sel, window_valid, win_row, win_col, busy, done, err, pixel_out};
        compared++;
        if (outs !== '0) begin mismatched++; $display("[TB] FAIL midreset_outputs: got %h, required 0", outs); end
        @(posedge clock);
        #1 rst_n = 1'b1;
        @(posedge clock);
        #1;
        compared++;
        if (done_cycle.size() != 0) begin mismatched++; $display("[TB] FAIL midreset_no_done: got %0d pulses, required 0", done_cycle.size()); end
        clear_logs();
        start_tile('h080, 4, 4);
        wait_done(100, "midreset");
        compared++;
        if (addr_log.size() != 16) begin mismatched++; $display("[TB] FAIL midreset_read_count: got %0d, required 16", addr_log.size()); end
        for (int i = 0; i < 16; i++) begin
            got = (i < addr_log.size()) ? addr_log[i] : -1;
            compared++;
            if (got != 'h080 + i) begin mismatched++; $display("[TB] FAIL midreset_addr[%0d]: got %h, required %h", i, got, 'h080 + i); end
        end
        repeat (2) @(posedge clock);
        #1;
        compared++;
        if (done_cycle.size() != 1) begin mismatched++; $display("[TB] FAIL midreset_done_pulses: got %0d, required 1", done_cycle.size()); end
    endtask

    task automatic test_start_busy();
        int got;
        int exp;
        clear_logs();
        start_tile('h3FE, 4, 3);
        repeat (3) @(posedge clock);
        #1;
        start_tile('h000, 8, 5);
        compared++;
        if (busy !== 1'b1 || err !== 1'b0) begin mismatched++; $display("[TB] FAIL busystart_state: got busy=%b err=%b, required busy=1 err=0", busy, err); end
        wait_done(100, "busystart");
        compared++;
        if (addr_log.size() != 12) begin mismatched++; $display("[TB] FAIL busystart_read_count: got %0d, required 12", addr_log.size()); end
        for (int i = 0; i < 12; i++) begin
            exp = ('h3FE + i) & 'h3FF;
            got = (i < addr_log.size()) ? addr_log[i] : -1;
            compared++;
            if (got != exp) begin mismatched++; $display("[TB] FAIL busystart_addr[%0d]: got %h, required %h", i, got, exp); end
        end
        compared++;
        if (sel !== 5'd3) begin mismatched++; $display("[TB] FAIL busystart_sel: got %0d, required 3", sel); end
        compared++;
        if (win_log.size() != 2) begin mismatched++; $display("[TB] FAIL busystart_window_count: got %0d, required 2", win_log.size()); end
        compared++;
        if (err_cnt != 0) begin mismatched++; $display("[TB] FAIL busystart_err: got %0d err cycles, required 0", err_cnt); end
        compared++;
        if (done_cycle.size() != 1) begin mismatched++; $display("[TB] FAIL busystart_done_pulses: got %0d, required 1", done_cycle.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wide();
        test_stall();
        test_illegal();
        test_reset_mid();
        test_start_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
